// File: rtl/ps2_scan_decoder.sv
// Purpose : pops PS/2 Set-2 scan bytes from the receiver FIFO and turns make/break/E0 sequences into key events.
// Latency : one byte per 3 cycles max (IDLE->POP->SETTLE); key_valid pulses the cycle after the POP cycle.
// Backpress: waits on ready=1; overflow=1 stalls everything in IDLE, drops pending prefixes, keeps held key/count.
//
// Ports:
//   clk, clrn            clock, async active-low reset
//   data[7:0], ready     receiver FIFO head byte / non-empty
//   overflow             receiver FIFO overflow flag
//   nextdata_n           active-low pop strobe (one cycle per consumed byte)
//   key_valid            one-cycle event pulse; key_code/ext/release/repeat describe it
//   key_down             level, a key is held
//   ascii[7:0]           lowercase ASCII of key_code (0x00 for extended or unmapped codes)
//   press_count[CNT_W-1:0] new-press counter, wraps
module ps2_scan_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic             key_repeat,
    output logic             key_down,
    output logic [7:0]       ascii,
    output logic [CNT_W-1:0] press_count
);

    typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

    state_t     state, state_nxt;
    logic [7:0] byte_r;
    logic       ext_flag, brk_flag;
    logic [8:0] held_code;      // {ext, code} of the key currently held
    logic       pop_en;

    always_comb begin
        state_nxt = state;
        pop_en    = 1'b0;
        if (overflow) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (ready) state_nxt = POP;
                POP: begin
                    pop_en    = 1'b1;
                    state_nxt = SETTLE;
                end
                SETTLE:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign nextdata_n = ~pop_en;

    logic       is_e0, is_f0, is_junk, is_event, same_held;
    logic [8:0] cur_code;

    assign is_e0     = (byte_r == 8'hE0);
    assign is_f0     = (byte_r == 8'hF0);
    // Keyboard status/ack bytes and error codes never describe a key.
    assign is_junk   = (byte_r == 8'hAA) || (byte_r == 8'hFA) || (byte_r == 8'hEE) ||
                       (byte_r == 8'hFE) || (byte_r == 8'h00) || (byte_r == 8'hFF);
    assign is_event  = pop_en && !is_e0 && !is_f0 && !is_junk;
    assign cur_code  = {ext_flag, byte_r};
    assign same_held = key_down && (cur_code == held_code);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            byte_r      <= 8'h00;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            held_code   <= 9'h000;
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
            key_down    <= 1'b0;
            press_count <= '0;
        end else begin
            state     <= state_nxt;
            key_valid <= is_event;

            if (state == IDLE && ready && !overflow)
                byte_r <= data;

            if (overflow) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (pop_en) begin
                if (is_e0) begin
                    ext_flag <= 1'b1;
                end else if (is_f0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end

            if (is_event) begin
                key_code    <= byte_r;
                key_ext     <= ext_flag;
                key_release <= brk_flag;
                if (brk_flag) begin
                    key_repeat <= 1'b0;
                    if (same_held)
                        key_down <= 1'b0;
                end else if (same_held) begin
                    // Typematic repeat of the held key is not a new press.
                    key_repeat <= 1'b1;
                end else begin
                    key_repeat  <= 1'b0;
                    key_down    <= 1'b1;
                    held_code   <= cur_code;
                    press_count <= press_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ascii = 8'h00;
        if (!key_ext) begin
            case (key_code)
                8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
                8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
                8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
                8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
                8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
                8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
                8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
                8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
                8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
                8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
                8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
                8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
                8'h46: ascii = 8'h39;
                8'h29: ascii = 8'h20; 8'h5A: ascii = 8'h0D; 8'h66: ascii = 8'h08;
                default: ascii = 8'h00;
            endcase
        end
    end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
Downstream consumer of the ps2_keyboard receiver. Pops raw scan-code bytes from the receiver FIFO using its ready/nextdata_n handshake. Parses PS/2 Set-2 make, break (F0) and extended (E0) sequences into one-cycle key events. Tracks the currently held key and a press counter, and supplies a lowercase ASCII translation for display and lab logic.

Parameters:
CNT_W, 8, width of the press counter.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
clrn  input  1  asynchronous active-low reset.
data  input  8  scan byte at the receiver FIFO head; valid while ready=1.
ready  input  1  receiver FIFO non-empty.
overflow  input  1  receiver FIFO overflow flag.
nextdata_n  output  1  active-low pop strobe to the receiver; exactly one cycle low per consumed byte.
key_valid  output  1  one-cycle pulse: a key event is on key_* outputs.
key_code  output  8  scan code of the last event; held until the next event.
key_ext  output  1  last event was E0-prefixed.
key_release  output  1  last event was a break.
key_repeat  output  1  last event was a typematic repeat of the held key.
key_down  output  1  level: a key is currently held.
ascii  output  8  ASCII of key_code when key_ext=0; 0x00 otherwise.
press_count  output  CNT_W  number of new key presses, wraps.

Behaviour:
- Reset (clrn=0, async): nextdata_n=1, key_valid=0, key_code=0x00, key_ext=0, key_release=0, key_repeat=0, key_down=0, press_count=0, ext_flag=0, brk_flag=0, held code=0x00, FSM=IDLE.
- Handshake FSM:
  - IDLE: if ready=1 and overflow=0, latch data into byte_r and go to POP.
  - POP: nextdata_n=0 for this cycle only; process byte_r; go to SETTLE.
  - SETTLE: nextdata_n=1; go to IDLE. This gives the receiver one cycle to update ready/data.
  - Maximum throughput is one byte per 3 cycles. nextdata_n is never low in two consecutive cycles.
- Byte processing, in POP:
  - 0xE0: ext_flag<=1. No event.
  - 0xF0: brk_flag<=1. No event.
  - 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF: discard the byte, clear both flags. No event.
  - Any other code C is an event. key_valid pulses in the cycle after POP. key_code<=C, key_ext<=ext_flag, key_release<=brk_flag. Both flags are cleared.
    - Break: key_repeat<=0. If key_down=1 and {ext_flag,C} equals the held code, key_down<=0. Otherwise key_down is unchanged.
    - Make with key_down=1 and the same {ext,C} as the held code: key_repeat<=1. press_count unchanged.
    - Make otherwise: key_repeat<=0, key_down<=1, held code<={ext_flag,C}, press_count<=press_count+1. press_count wraps from 2^CNT_W-1 to 0.
- ascii is combinational from key_code/key_ext:
  - 1C→'a' … 1A→'z' using the standard Set-2 letter map.
  - 45,16,1E,26,25,2E,36,3D,3E,46 → '0'..'9'.
  - 29→0x20, 5A→0x0D, 66→0x08.
  - All other codes, and any code with key_ext=1, → 0x00.
- overflow=1: FSM forced to IDLE, nextdata_n=1, ext_flag and brk_flag cleared. No pops and no events while overflow is high. key_down and press_count are retained.
- An E0 or F0 prefix is kept across any number of idle cycles; there is no timeout.
- Asserting clrn mid-sequence (for example after F0) fully restarts decoding. The next byte is treated as a fresh make.

Test Plan:
- Feed 1C then F0 1C → first event: key_code=1C, ascii=0x61, key_release=0, press_count=1, key_down=1. Second event: key_release=1, key_down=0. nextdata_n low exactly 3 times.
- Feed 1C,1C,1C → 3 key_valid pulses, the last two with key_repeat=1. press_count=1.
- Feed E0 75 then E0 F0 75 → key_ext=1, ascii=0x00, make then release. press_count increments by 1.
- Feed F0 with overflow raised for 5 cycles, then 1C → prefix dropped. Event is a make, key_release=0. No nextdata_n pulses while overflow=1.
- Feed 256 distinct alternating makes 1C,32 with CNT_W=8 → press_count returns to 0x00. Each key_valid is exactly 1 cycle wide.
- Feed F0, assert clrn=0 for 2 cycles, then feed 16 → all outputs at reset values during reset. Afterwards: make event, key_code=16, ascii=0x31.
